// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: producer handshake, register-file write port
// and the two shared read ports with their bypassed results.
interface wb_queue_if #(
  parameter int n = 8
);
  logic           req_valid;
  logic           req_ready;
  logic [4:0]     req_addr;
  logic [n-1:0]   req_data;
  logic           stall;
  logic           w;
  logic [4:0]     Waddr;
  logic [n-1:0]   Wdata;
  logic [4:0]     Raddr1;
  logic [4:0]     Raddr2;
  logic [n-1:0]   Rfile1;
  logic [n-1:0]   Rfile2;
  logic [n-1:0]   Rdata1;
  logic [n-1:0]   Rdata2;
  logic [2:0]     count;

  // The queue side
  modport slave (
    input  req_valid, req_addr, req_data, stall,
           Raddr1, Raddr2, Rfile1, Rfile2,
    output req_ready, w, Waddr, Wdata, Rdata1, Rdata2, count
  );

  // The producer / register-file side
  modport master (
    output req_valid, req_addr, req_data, stall,
           Raddr1, Raddr2, Rfile1, Rfile2,
    input  req_ready, w, Waddr, Wdata, Rdata1, Rdata2, count
  );
endinterface

// File: rtl/wb_queue.sv
// Four-entry pending-write queue in front of a register file. Writes are
// drained in acceptance order, one per cycle unless stalled, and reads are
// bypassed from the youngest pending write to the same register.
module wb_queue #(
  parameter int n = 8
) (
  input  logic       clk,
  input  logic       reset,
  wb_queue_if.slave  bus
);
  localparam int DEPTH = 4;

  logic [4:0]   r_mem_addr [DEPTH];
  logic [n-1:0] r_mem_data [DEPTH];
  logic [1:0]   r_head;
  logic [1:0]   r_tail;
  logic [2:0]   r_count;

  logic         w_ready;
  logic         w_push;
  logic         w_pop;
  logic         w_nonempty;
  logic [n-1:0] w_rdata1;
  logic [n-1:0] w_rdata2;

  assign w_ready    = (r_count < 3'(DEPTH));
  assign w_nonempty = (r_count != 3'd0);
  // Writes to register 0 complete the handshake but are never stored.
  assign w_push     = bus.req_valid && w_ready && (bus.req_addr != 5'd0);
  assign w_pop      = w_nonempty && !bus.stall;

  // Pointers and occupancy; validity of entries is defined by count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_tail <= r_tail + 2'd1;
      if (w_pop)  r_head <= r_head + 2'd1;
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

  // Entry storage is not reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= bus.req_addr;
      r_mem_data[r_tail] <= bus.req_data;
    end
  end

  // Bypass: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_rdata1 = bus.Rfile1;
    w_rdata2 = bus.Rfile2;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(r_count)) begin
        if (r_mem_addr[r_head + 2'(i)] == bus.Raddr1) w_rdata1 = r_mem_data[r_head + 2'(i)];
        if (r_mem_addr[r_head + 2'(i)] == bus.Raddr2) w_rdata2 = r_mem_data[r_head + 2'(i)];
      end
    end
    if (bus.Raddr1 == 5'd0) w_rdata1 = '0;
    if (bus.Raddr2 == 5'd0) w_rdata2 = '0;
  end

  assign bus.req_ready = w_ready;
  assign bus.count     = r_count;
  assign bus.w         = w_pop;
  assign bus.Waddr     = w_nonempty ? r_mem_addr[r_head] : 5'd0;
  assign bus.Wdata     = w_nonempty ? r_mem_data[r_head] : '0;
  assign bus.Rdata1    = w_rdata1;
  assign bus.Rdata2    = w_rdata2;
endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_wb_queue;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  wb_queue_if #(.n(8)) bus ();

  wb_queue #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] a;
    logic [7:0] d;
    logic       st;
    logic [4:0] ra;
    logic [7:0] rf;
    logic       e_rdy;
    logic       e_w;
    logic [4:0] e_wa;
    logic [7:0] e_wd;
    logic [2:0] e_cnt;
    logic [7:0] e_rd;
  } vec_t;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } ent_t;

  vec_t tbl [12];
  ent_t q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_addr  = 5'd0;
    bus.req_data  = 8'd0;
    bus.stall     = 1'b0;
    bus.Raddr1    = 5'd0;
    bus.Raddr2    = 5'd0;
    bus.Rfile1    = 8'd0;
    bus.Rfile2    = 8'd0;
  endtask

  task automatic offer(input logic v, input logic [4:0] a, input logic [7:0] d);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] ra, input logic [7:0] rf);
    if (ra == 5'd0) return 8'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == ra) return q[i].d;
    return rf;
  endfunction

  initial begin
    logic       e_w;
    logic       e_rdy;
    logic [4:0] e_wa;
    logic [7:0] e_wd;
    ent_t       e;

    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset state
    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_w", 32'(bus.w), 32'd0);
    chk("rst_waddr", 32'(bus.Waddr), 32'd0);
    chk("rst_wdata", 32'(bus.Wdata), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    reset = 1'b0;

    // Directed vectors: two back-to-back writes, a write to r0, bypass with stall
    //            v  a     d       st  ra     rf      rdy w  wa     wd      cnt   rd
    tbl[0]  = '{1'b1, 5'd1, 8'd11,  1'b0, 5'd0, 8'hAA, 1'b1, 1'b0, 5'd0, 8'd0,  3'd0, 8'h00};
    tbl[1]  = '{1'b1, 5'd2, 8'd12,  1'b0, 5'd1, 8'h00, 1'b1, 1'b1, 5'd1, 8'd11, 3'd1, 8'd11};
    tbl[2]  = '{1'b0, 5'd0, 8'd0,   1'b0, 5'd2, 8'h05, 1'b1, 1'b1, 5'd2, 8'd12, 3'd1, 8'd12};
    tbl[3]  = '{1'b0, 5'd0, 8'd0,   1'b0, 5'd2, 8'h05, 1'b1, 1'b0, 5'd0, 8'd0,  3'd0, 8'h05};
    tbl[4]  = '{1'b1, 5'd0, 8'hFF,  1'b0, 5'd0, 8'hAA, 1'b1, 1'b0, 5'd0, 8'd0,  3'd0, 8'h00};
    tbl[5]  = '{1'b0, 5'd0, 8'd0,   1'b0, 5'd0, 8'hAA, 1'b1, 1'b0, 5'd0, 8'd0,  3'd0, 8'h00};
    tbl[6]  = '{1'b1, 5'd5, 8'h10,  1'b1, 5'd5, 8'h00, 1'b1, 1'b0, 5'd0, 8'd0,  3'd0, 8'h00};
    tbl[7]  = '{1'b1, 5'd5, 8'h20,  1'b1, 5'd5, 8'h00, 1'b1, 1'b0, 5'd5, 8'h10, 3'd1, 8'h10};
    tbl[8]  = '{1'b0, 5'd0, 8'd0,   1'b1, 5'd5, 8'h00, 1'b1, 1'b0, 5'd5, 8'h10, 3'd2, 8'h20};
    tbl[9]  = '{1'b0, 5'd0, 8'd0,   1'b0, 5'd5, 8'h00, 1'b1, 1'b1, 5'd5, 8'h10, 3'd2, 8'h20};
    tbl[10] = '{1'b0, 5'd0, 8'd0,   1'b0, 5'd5, 8'h00, 1'b1, 1'b1, 5'd5, 8'h20, 3'd1, 8'h20};
    tbl[11] = '{1'b0, 5'd0, 8'd0,   1'b0, 5'd5, 8'h33, 1'b1, 1'b0, 5'd0, 8'd0,  3'd0, 8'h33};

    for (int i = 0; i < 12; i++) begin
      offer(tbl[i].v, tbl[i].a, tbl[i].d);
      bus.stall  = tbl[i].st;
      bus.Raddr1 = tbl[i].ra;
      bus.Rfile1 = tbl[i].rf;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_w", i), 32'(bus.w), 32'(tbl[i].e_w));
      chk($sformatf("vec%0d_waddr", i), 32'(bus.Waddr), 32'(tbl[i].e_wa));
      chk($sformatf("vec%0d_wdata", i), 32'(bus.Wdata), 32'(tbl[i].e_wd));
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_rdata1", i), 32'(bus.Rdata1), 32'(tbl[i].e_rd));
      tick();
    end
    idle_inputs();

    // Fill under stall: five offers, fifth refused; then drain in order
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 5'(3 + i), 8'(8'h30 + i));
      #1;
      chk($sformatf("full%0d_ready", i), 32'(bus.req_ready), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("full%0d_count", i), 32'(bus.count), (i < 4) ? 32'(i) : 32'd4);
      chk($sformatf("full%0d_w", i), 32'(bus.w), 32'd0);
      tick();
    end
    offer(1'b0, 5'd0, 8'd0);
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d_w", i), 32'(bus.w), 32'd1);
      chk($sformatf("drain%0d_waddr", i), 32'(bus.Waddr), 32'(3 + i));
      chk($sformatf("drain%0d_wdata", i), 32'(bus.Wdata), 32'(8'h30 + i));
      chk($sformatf("drain%0d_count", i), 32'(bus.count), 32'(4 - i));
      tick();
    end
    #1;
    chk("drain_end_count", 32'(bus.count), 32'd0);
    chk("drain_end_w", 32'(bus.w), 32'd0);
    tick();

    // Steady accept+pop at count 2, wrapping the pointers twice
    bus.stall = 1'b1;
    offer(1'b1, 5'd1, 8'd1);
    tick();
    offer(1'b1, 5'd2, 8'd2);
    tick();
    bus.stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      offer(1'b1, 5'(3 + k), 8'(3 + k));
      #1;
      chk($sformatf("wrap%0d_count", k), 32'(bus.count), 32'd2);
      chk($sformatf("wrap%0d_w", k), 32'(bus.w), 32'd1);
      chk($sformatf("wrap%0d_waddr", k), 32'(bus.Waddr), 32'(k + 1));
      chk($sformatf("wrap%0d_wdata", k), 32'(bus.Wdata), 32'(k + 1));
      tick();
    end
    offer(1'b0, 5'd0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("wraptail%0d_waddr", k), 32'(bus.Waddr), 32'(7 + k));
      chk($sformatf("wraptail%0d_wdata", k), 32'(bus.Wdata), 32'(7 + k));
      tick();
    end
    #1;
    chk("wrap_end_count", 32'(bus.count), 32'd0);
    tick();

    // Asynchronous reset with three writes pending
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 5'(9 + i), 8'(8'h90 + i));
      tick();
    end
    offer(1'b0, 5'd0, 8'd0);
    bus.stall = 1'b0;
    #1;
    chk("prerst_count", 32'(bus.count), 32'd3);
    chk("prerst_w", 32'(bus.w), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_w", 32'(bus.w), 32'd0);
    chk("arst_waddr", 32'(bus.Waddr), 32'd0);
    chk("arst_wdata", 32'(bus.Wdata), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("postrst%0d_w", i), 32'(bus.w), 32'd0);
      chk($sformatf("postrst%0d_count", i), 32'(bus.count), 32'd0);
      tick();
    end

    // Randomized traffic against the reference queue model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = ($urandom_range(0, 99) < 60);
      bus.req_addr  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      bus.req_data  = 8'($urandom);
      bus.stall     = ($urandom_range(0, 99) < 35);
      bus.Raddr1    = 5'($urandom_range(0, 7));
      bus.Raddr2    = 5'($urandom_range(0, 7));
      bus.Rfile1    = 8'($urandom);
      bus.Rfile2    = 8'($urandom);
      #1;
      e_rdy = (q.size() < 4);
      e_w   = (q.size() != 0) && !bus.stall;
      e_wa  = (q.size() != 0) ? q[0].a : 5'd0;
      e_wd  = (q.size() != 0) ? q[0].d : 8'd0;
      chk("rnd_ready", 32'(bus.req_ready), 32'(e_rdy));
      chk("rnd_w", 32'(bus.w), 32'(e_w));
      chk("rnd_waddr", 32'(bus.Waddr), 32'(e_wa));
      chk("rnd_wdata", 32'(bus.Wdata), 32'(e_wd));
      chk("rnd_count", 32'(bus.count), 32'(q.size()));
      chk("rnd_rdata1", 32'(bus.Rdata1), 32'(model_read(bus.Raddr1, bus.Rfile1)));
      chk("rnd_rdata2", 32'(bus.Rdata2), 32'(model_read(bus.Raddr2, bus.Rfile2)));
      if (e_w) void'(q.pop_front());
      if (bus.req_valid && e_rdy && bus.req_addr != 5'd0) begin
        e.a = bus.req_addr;
        e.d = bus.req_data;
        q.push_back(e);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
